// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, access-type encoding,
// FSM states and the access-length decode.
package mem_stage_pkg;

    localparam int   RegLen      = 32;
    localparam int   RegAddrLen  = 5;
    localparam int   OpCodeLen   = 7;
    localparam int   PipelineNum = 6;
    localparam logic ResetEnable = 1'b1;

    // bit 3 = store, low bits = funct3
    localparam logic [3:0] LS_LB  = 4'h0;
    localparam logic [3:0] LS_LH  = 4'h1;
    localparam logic [3:0] LS_LW  = 4'h2;
    localparam logic [3:0] LS_LBU = 4'h4;
    localparam logic [3:0] LS_LHU = 4'h5;
    localparam logic [3:0] LS_SB  = 4'h8;
    localparam logic [3:0] LS_SH  = 4'h9;
    localparam logic [3:0] LS_SW  = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Byte count of an access; 0 marks a type that is not valid for the direction.
    function automatic logic [2:0] ls_len(input logic is_load, input logic [3:0] ls_type);
        logic [2:0] len;
        len = 3'd0;
        if (is_load) begin
            case (ls_type)
                LS_LB, LS_LBU: len = 3'd1;
                LS_LH, LS_LHU: len = 3'd2;
                LS_LW:         len = 3'd4;
                default:       len = 3'd0;
            endcase
        end else begin
            case (ls_type)
                LS_SB:   len = 3'd1;
                LS_SH:   len = 3'd2;
                LS_SW:   len = 3'd4;
                default: len = 3'd0;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of the assembled load buffer to a 32-bit register value.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_buf,
    input  logic [3:0]  i_type,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_buf;
        case (i_type)
            LS_LB:   o_data = {{24{i_buf[7]}}, i_buf[7:0]};
            LS_LBU:  o_data = {24'd0, i_buf[7:0]};
            LS_LH:   o_data = {{16{i_buf[15]}}, i_buf[15:0]};
            LS_LHU:  o_data = {16'd0, i_buf[15:0]};
            default: o_data = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores with pipeline stall; non-memory ops pass through.
// state  | meaning
// IDLE   | pass-through, or stall and start an access when an enable is set
// ACCESS | one byte request per step, counter selects the byte
// DONE   | result presented; held until EX/MEM advances
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STALL_BIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_enable_i,
    input  logic        load_enable_i,
    input  logic        store_enable_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  load_store_type_i,
    input  logic [5:0]  stall_i,
    output logic        stall_req_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_done_i,
    output logic [31:0] wb_rd_data_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic        wb_rd_enable_o
);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_buf;

    state_t      w_state_nxt;
    logic [1:0]  w_cnt_nxt;
    logic        w_buf_wr;
    logic        w_is_load;
    logic        w_is_store;
    logic [2:0]  w_len;
    logic        w_mem_op;
    logic        w_last;
    logic [31:0] w_ext;
    logic        w_unused_stall;

    // Load wins when both enables are set.
    assign w_is_load      = load_enable_i;
    assign w_is_store     = store_enable_i & ~load_enable_i;
    assign w_len          = (w_is_load | w_is_store) ? ls_len(w_is_load, load_store_type_i) : 3'd0;
    assign w_mem_op       = (w_len != 3'd0);
    assign w_last         = ({1'b0, r_cnt} == (w_len - 3'd1));
    assign w_unused_stall = ^stall_i;

    mem_stage_load_extend u_load_extend (
        .i_buf  (r_buf),
        .i_type (load_store_type_i),
        .o_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_buf   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_buf_wr) begin
                r_buf[{r_cnt, 3'b000} +: 8] <= mem_rdata_i;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_buf_wr       = 1'b0;
        stall_req_o    = 1'b0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = 32'd0;
        mem_wdata_o    = 8'd0;
        wb_rd_data_o   = 32'd0;
        wb_rd_addr_o   = 5'd0;
        wb_rd_enable_o = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    stall_req_o = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    wb_rd_data_o   = rd_data_i;
                    wb_rd_addr_o   = rd_addr_i;
                    wb_rd_enable_o = rd_enable_i;
                end
            end
            ST_ACCESS: begin
                stall_req_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = w_is_store;
                mem_addr_o  = mem_addr_i + {30'd0, r_cnt};
                mem_wdata_o = rd_data_i[{r_cnt, 3'b000} +: 8];
                if (mem_done_i) begin
                    w_buf_wr = w_is_load;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (w_is_load) begin
                    wb_rd_data_o   = w_ext;
                    wb_rd_addr_o   = rd_addr_i;
                    wb_rd_enable_o = rd_enable_i;
                end
                if (!stall_i[STALL_BIT]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are forced low for the whole reset cycle, not just after the edge.
        if (rst) begin
            stall_req_o    = 1'b0;
            mem_req_o      = 1'b0;
            mem_we_o       = 1'b0;
            mem_addr_o     = 32'd0;
            mem_wdata_o    = 8'd0;
            wb_rd_data_o   = 32'd0;
            wb_rd_addr_o   = 5'd0;
            wb_rd_enable_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a bench-driven byte memory controller.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_enable_i;
    logic        load_enable_i;
    logic        store_enable_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  load_store_type_i;
    logic [5:0]  stall_i;
    logic        stall_req_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_done_i;
    logic [31:0] wb_rd_data_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_rd_enable_o;

    int n_chk;
    int n_fail;

    mem_stage #(.STALL_BIT(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_data_i         (rd_data_i),
        .rd_addr_i         (rd_addr_i),
        .rd_enable_i       (rd_enable_i),
        .load_enable_i     (load_enable_i),
        .store_enable_i    (store_enable_i),
        .mem_addr_i        (mem_addr_i),
        .load_store_type_i (load_store_type_i),
        .stall_i           (stall_i),
        .stall_req_o       (stall_req_o),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_rdata_i       (mem_rdata_i),
        .mem_done_i        (mem_done_i),
        .wb_rd_data_o      (wb_rd_data_o),
        .wb_rd_addr_o      (wb_rd_addr_o),
        .wb_rd_enable_o    (wb_rd_enable_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [31:0] data, input logic [4:0] addr);
        rd_data_i         = data;
        rd_addr_i         = addr;
        rd_enable_i       = 1'b1;
        load_enable_i     = 1'b0;
        store_enable_i    = 1'b0;
        mem_addr_i        = 32'd0;
        load_store_type_i = 4'h0;
    endtask

    // Runs one memory instruction from IDLE through DONE and back to IDLE.
    // wait_byte: byte index that gets one extra cycle before done; hold: extra DONE cycles.
    task automatic run_mem(input string tag, input logic ld, input logic st,
                           input logic [3:0] ty, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rbytes,
                           input int len, input logic [31:0] exp_wb, input logic exp_en,
                           input int wait_byte, input int hold);
        logic [31:0] wd;
        wd                = wdata;
        rd_data_i         = wdata;
        rd_addr_i         = 5'd9;
        rd_enable_i       = 1'b1;
        load_enable_i     = ld;
        store_enable_i    = st;
        mem_addr_i        = addr;
        load_store_type_i = ty;
        mem_done_i        = 1'b0;
        stall_i           = 6'd0;
        #1;
        chk({tag, " idle stall_req"}, {31'd0, stall_req_o}, 32'd1);
        chk({tag, " idle mem_req"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, " idle wb_en"}, {31'd0, wb_rd_enable_o}, 32'd0);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            mem_done_i = 1'b0;
            chk({tag, " req"}, {31'd0, mem_req_o}, 32'd1);
            chk({tag, " addr"}, mem_addr_o, addr + i);
            chk({tag, " we"}, {31'd0, mem_we_o}, {31'd0, st & ~ld});
            chk({tag, " acc stall_req"}, {31'd0, stall_req_o}, 32'd1);
            chk({tag, " acc wb_en"}, {31'd0, wb_rd_enable_o}, 32'd0);
            if (st && !ld) chk({tag, " wdata"}, {24'd0, mem_wdata_o}, {24'd0, wd[8*i +: 8]});
            if (i == wait_byte) begin
                @(posedge clk);
                #1;
                chk({tag, " wait req"}, {31'd0, mem_req_o}, 32'd1);
                chk({tag, " wait addr"}, mem_addr_o, addr + i);
            end
            mem_rdata_i = rbytes[8*i +: 8];
            mem_done_i  = 1'b1;
        end
        @(posedge clk);
        #1;
        mem_done_i = 1'b0;
        if (hold > 0) stall_i = 6'b001000;
        chk({tag, " done stall_req"}, {31'd0, stall_req_o}, 32'd0);
        chk({tag, " done mem_req"}, {31'd0, mem_req_o}, 32'd0);
        chk({tag, " done wb_en"}, {31'd0, wb_rd_enable_o}, {31'd0, exp_en});
        if (exp_en) begin
            chk({tag, " done wb_data"}, wb_rd_data_o, exp_wb);
            chk({tag, " done wb_addr"}, {27'd0, wb_rd_addr_o}, 32'd9);
        end
        for (int h = 0; h < hold; h++) begin
            // A spurious done while holding must not restart anything.
            mem_done_i = 1'b1;
            @(posedge clk);
            #1;
            mem_done_i = 1'b0;
            if (h == hold - 1) stall_i = 6'd0;
            chk({tag, " hold mem_req"}, {31'd0, mem_req_o}, 32'd0);
            chk({tag, " hold stall_req"}, {31'd0, stall_req_o}, 32'd0);
            chk({tag, " hold wb_data"}, wb_rd_data_o, exp_wb);
            chk({tag, " hold wb_en"}, {31'd0, wb_rd_enable_o}, {31'd0, exp_en});
        end
        @(posedge clk);
        #1;
        set_alu(32'h0000_0042, 5'd3);
        #1;
        chk({tag, " back idle wb_en"}, {31'd0, wb_rd_enable_o}, 32'd1);
        chk({tag, " back idle wb_data"}, wb_rd_data_o, 32'h42);
        chk({tag, " back idle stall_req"}, {31'd0, stall_req_o}, 32'd0);
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        stall_i     = 6'd0;
        mem_rdata_i = 8'd0;
        mem_done_i  = 1'b0;
        set_alu(32'h0000_0007, 5'd5);
        repeat (2) @(posedge clk);
        #1;
        chk("rst wb_data", wb_rd_data_o, 32'd0);
        chk("rst wb_addr", {27'd0, wb_rd_addr_o}, 32'd0);
        chk("rst wb_en", {31'd0, wb_rd_enable_o}, 32'd0);
        chk("rst stall_req", {31'd0, stall_req_o}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);

        rst = 1'b0;
        #1;
        chk("add wb_data", wb_rd_data_o, 32'h7);
        chk("add wb_addr", {27'd0, wb_rd_addr_o}, 32'd5);
        chk("add wb_en", {31'd0, wb_rd_enable_o}, 32'd1);
        chk("add stall_req", {31'd0, stall_req_o}, 32'd0);
        chk("add mem_req", {31'd0, mem_req_o}, 32'd0);

        // Unknown type with the load enable set behaves like an ALU op.
        set_alu(32'h0000_0055, 5'd6);
        load_enable_i     = 1'b1;
        load_store_type_i = 4'h3;
        #1;
        chk("unk stall_req", {31'd0, stall_req_o}, 32'd0);
        chk("unk wb_data", wb_rd_data_o, 32'h55);
        @(posedge clk);
        #1;
        chk("unk mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("unk wb_en", {31'd0, wb_rd_enable_o}, 32'd1);

        run_mem("lw",  1'b1, 1'b0, 4'h2, 32'h0000_1000, 32'h0, 32'h1234_5678, 4,
                32'h1234_5678, 1'b1, 1, 0);
        run_mem("lb",  1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h0000_0080, 1,
                32'hFFFF_FF80, 1'b1, -1, 0);
        run_mem("lbu", 1'b1, 1'b1, 4'h4, 32'h0000_0020, 32'h0, 32'h0000_0080, 1,
                32'h0000_0080, 1'b1, -1, 0);
        run_mem("sh",  1'b0, 1'b1, 4'h9, 32'h0000_2001, 32'hABCD_1234, 32'h0, 2,
                32'h0, 1'b0, -1, 0);
        run_mem("lw_wrap", 1'b1, 1'b0, 4'h2, 32'hFFFF_FFFE, 32'h0, 32'hA1B2_C3D4, 4,
                32'hA1B2_C3D4, 1'b1, -1, 0);

        // Reset in the middle of a word load, after two bytes completed.
        rd_data_i         = 32'h0;
        rd_addr_i         = 5'd9;
        rd_enable_i       = 1'b1;
        load_enable_i     = 1'b1;
        store_enable_i    = 1'b0;
        mem_addr_i        = 32'h0000_3000;
        load_store_type_i = 4'h2;
        @(posedge clk);
        #1;
        mem_rdata_i = 8'h11;
        mem_done_i  = 1'b1;
        @(posedge clk);
        #1;
        mem_rdata_i = 8'h22;
        @(posedge clk);
        #1;
        mem_done_i = 1'b0;
        chk("mid addr", mem_addr_o, 32'h0000_3002);
        rst = 1'b1;
        #1;
        chk("mid rst mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("mid rst stall_req", {31'd0, stall_req_o}, 32'd0);
        chk("mid rst mem_addr", mem_addr_o, 32'd0);
        chk("mid rst wb_en", {31'd0, wb_rd_enable_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_alu(32'h0000_0007, 5'd5);
        #1;
        chk("post rst wb_data", wb_rd_data_o, 32'h7);
        chk("post rst wb_en", {31'd0, wb_rd_enable_o}, 32'd1);
        chk("post rst mem_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("post rst idle mem_req", {31'd0, mem_req_o}, 32'd0);
        run_mem("lb2", 1'b1, 1'b0, 4'h0, 32'h0000_0044, 32'h0, 32'h0000_007F, 1,
                32'h0000_007F, 1'b1, -1, 0);

        // Half-word load held in DONE for three cycles by stall_i[3].
        run_mem("lh_hold", 1'b1, 1'b0, 4'h1, 32'h0000_0040, 32'h0, 32'h0000_FFFE, 2,
                32'hFFFF_FFFE, 1'b1, -1, 2);
        run_mem("lhu", 1'b1, 1'b0, 4'h5, 32'h0000_0040, 32'h0, 32'h0000_8001, 2,
                32'h0000_8001, 1'b1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs and performs loads/stores over the 8-bit byte-serial memory-controller port.
- Stalls the pipeline while an access is in progress.
- Presents the final rd write-back fields to the MEM/WB register; non-memory instructions pass through with zero added latency.

Parameters:
STALL_BIT, 3, index of the stall_i bit that freezes EX/MEM (the hold condition for the DONE state)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rd_data_i  in  32  ALU result; for stores, the store data
rd_addr_i  in  5  destination register
rd_enable_i  in  1  destination write enable
load_enable_i  in  1  instruction is a load
store_enable_i  in  1  instruction is a store
mem_addr_i  in  32  effective byte address
load_store_type_i  in  4  access type, see package encoding
stall_i  in  6  pipeline stall vector from stall_ctrl
stall_req_o  out  1  stall request to stall_ctrl
mem_req_o  out  1  byte request to memory controller
mem_we_o  out  1  1 = write byte, 0 = read byte
mem_addr_o  out  32  byte address
mem_wdata_o  out  8  write byte
mem_rdata_i  in  8  read byte, valid with mem_done_i
mem_done_i  in  1  one-cycle pulse: current byte complete
wb_rd_data_o  out  32  write-back data
wb_rd_addr_o  out  5  write-back register
wb_rd_enable_o  out  1  write-back enable

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- While rst=1, every output is 0 (combinationally gated). The FSM enters IDLE and the byte counter and load buffer clear at the edge.
- Access length: LB/LBU/SB = 1, LH/LHU/SH = 2, LW/SW = 4 bytes.
  - Little-endian, byte i at mem_addr_i+i, mod 2^32.
  - No alignment check.
- If load_enable_i and store_enable_i are both 1, the load wins.
- An unknown type with an enable set is treated as a non-memory op: pass-through, no access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No enable set: wb_* = rd_*_i combinationally; stall_req_o=0; mem_req_o=0.
  - Enable set: stall_req_o=1 combinationally in the same cycle; next state ACCESS with cnt=0.
- ACCESS:
  - Outputs: mem_req_o=1; mem_we_o=store; mem_addr_o=mem_addr_i+cnt; mem_wdata_o=rd_data_i[8*cnt+7:8*cnt]; stall_req_o=1; wb_rd_enable_o=0.
  - On mem_done_i for a load: buf[8*cnt+7:8*cnt] <= mem_rdata_i.
  - On mem_done_i: if cnt==len-1, next state DONE; else cnt++.
  - The request stays asserted between bytes; the controller samples the new address the cycle after done.
- DONE:
  - stall_req_o=0; mem_req_o=0.
  - Load: wb_rd_data_o = buf sign- or zero-extended per type; wb_rd_addr_o=rd_addr_i; wb_rd_enable_o=rd_enable_i.
  - Store: wb_rd_enable_o=0.
  - Leave for IDLE when stall_i[STALL_BIT]==0, i.e. when EX/MEM advances. Otherwise hold DONE, so the same instruction is never re-executed.
- mem_done_i outside ACCESS is ignored.
- Minimum load/store latency: len+1 stall cycles, given mem_done_i on each byte's first cycle.
- Reset mid-ACCESS: mem_req_o drops immediately, partial bytes are discarded, and the FSM is IDLE after the edge.
- Back-to-back memory instructions: the next one is seen in IDLE the cycle after DONE.

Decomposition:
- Shared defines package:
  - RegLen, RegAddrLen, OpCodeLen, PipelineNum, ResetEnable.
  - load_store_type encoding: LB=4'h0, LH=4'h1, LW=4'h2, LBU=4'h4, LHU=4'h5, SB=4'h8, SH=4'h9, SW=4'hA (bit 3 = store, low bits = funct3).
  - FSM state localparams.
- One sub-module, load_extend: combinational buffer plus type to 32-bit sign/zero extension.

Test Plan:
- ADD result 0x00000007 to x5, no enables -> wb_rd_data_o=0x7, wb_rd_addr_o=5, wb_rd_enable_o=1 in the same cycle; stall_req_o stays 0.
- LW at 0x1000, memory returns 0x78, 0x56, 0x34, 0x12 -> 4 requests at 0x1000-0x1003 with mem_we_o=0; stall held until DONE; wb_rd_data_o=0x12345678.
- LB and then LBU at 0x20 returning 0x80 -> wb_rd_data_o=0xFFFFFF80, then 0x00000080.
- SH with rd_data_i=0xABCD1234 at 0x2001 -> writes 0x34@0x2001 and 0x12@0x2002 with mem_we_o=1; wb_rd_enable_o=0 in DONE.
- LW with rst asserted after 2 bytes done -> mem_req_o=0 and all outputs 0 during reset; IDLE after the edge; a following ADD passes through normally.
- LH reaching DONE with stall_i[3]=1 for 3 cycles -> no new mem_req_o; wb result stable; IDLE only after stall_i[3]=0.
